// File: rtl/rs_issue_queue.sv
`default_nettype none
// ============================================================================
//  Module      : rs_issue_queue
//  Description : Clocked reservation station. Accepts up to DISP_W renamed
//                instructions per cycle into the lowest free entries, captures
//                operands from dispatch data or wakeup broadcasts (including
//                same-cycle bypass at dispatch), and issues up to one ready
//                instruction per functional unit per cycle through registered
//                valid/ready issue ports.
//  Configuration macro:
//                RS_AGE_PRIO_EN - when defined, a DEPTH x DEPTH age matrix makes
//                each port pick its oldest ready candidate; when undefined
//                each port picks its lowest-indexed ready candidate.
//  Ports       :
//    clk, rst_n             clock, asynchronous active-low reset
//    flush                  synchronous clear of entries and issue registers
//    disp_*                 DISP_W dispatch slots (flattened, slot 0 in LSBs)
//    disp_ready             all DISP_W slots can be accepted this cycle
//    wk_valid/wk_preg/wk_data  WAKE_W wakeup broadcasts
//    iss_valid/iss_ready    per-FU issue handshake
//    iss_*                  per-FU issued fields (flattened, FU 0 in LSBs)
//    occ_count              number of valid entries
//  Revision    : 1.0 - initial release
// ============================================================================
module rs_issue_queue #(
    parameter  int DEPTH  = 16,
    parameter  int DISP_W = 2,
    parameter  int NUM_FU = 3,
    parameter  int WAKE_W = 3,
    parameter  int PREG_W = 6,
    parameter  int DATA_W = 32,
    parameter  int ROB_W  = 4,
    localparam int FU_W   = (NUM_FU > 1) ? $clog2(NUM_FU) : 1,
    localparam int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic [DISP_W-1:0]        disp_valid,
    output logic                     disp_ready,
    input  logic [DISP_W*7-1:0]      disp_op,
    input  logic [DISP_W*3-1:0]      disp_func3,
    input  logic [DISP_W*7-1:0]      disp_func7,
    input  logic [DISP_W*PREG_W-1:0] disp_pd,
    input  logic [DISP_W*PREG_W-1:0] disp_ps1,
    input  logic [DISP_W*PREG_W-1:0] disp_ps2,
    input  logic [DISP_W-1:0]        disp_src1_rdy,
    input  logic [DISP_W-1:0]        disp_src2_rdy,
    input  logic [DISP_W*DATA_W-1:0] disp_src1_data,
    input  logic [DISP_W*DATA_W-1:0] disp_src2_data,
    input  logic [DISP_W*ROB_W-1:0]  disp_rob_idx,
    input  logic [DISP_W*FU_W-1:0]   disp_fu_idx,
    input  logic [WAKE_W-1:0]        wk_valid,
    input  logic [WAKE_W*PREG_W-1:0] wk_preg,
    input  logic [WAKE_W*DATA_W-1:0] wk_data,
    output logic [NUM_FU-1:0]        iss_valid,
    input  logic [NUM_FU-1:0]        iss_ready,
    output logic [NUM_FU*7-1:0]      iss_op,
    output logic [NUM_FU*3-1:0]      iss_func3,
    output logic [NUM_FU*7-1:0]      iss_func7,
    output logic [NUM_FU*DATA_W-1:0] iss_src1,
    output logic [NUM_FU*DATA_W-1:0] iss_src2,
    output logic [NUM_FU*PREG_W-1:0] iss_pd,
    output logic [NUM_FU*ROB_W-1:0]  iss_rob_idx,
    output logic [CNT_W-1:0]         occ_count
);

    localparam int c_IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int c_SLOT_W = (DISP_W > 1) ? $clog2(DISP_W) : 1;

    // ---------------- entry state ----------------
    logic [DEPTH-1:0]  r_valid, r_rdy1, r_rdy2;
    logic [6:0]        r_op    [DEPTH];
    logic [2:0]        r_func3 [DEPTH];
    logic [6:0]        r_func7 [DEPTH];
    logic [PREG_W-1:0] r_pd    [DEPTH];
    logic [PREG_W-1:0] r_ps1   [DEPTH];
    logic [PREG_W-1:0] r_ps2   [DEPTH];
    logic [DATA_W-1:0] r_data1 [DEPTH];
    logic [DATA_W-1:0] r_data2 [DEPTH];
    logic [ROB_W-1:0]  r_rob   [DEPTH];
    logic [FU_W-1:0]   r_fu    [DEPTH];
    logic [CNT_W-1:0]  r_count;

    // ---------------- issue registers ----------------
    logic [NUM_FU-1:0]        r_iss_valid;
    logic [NUM_FU*7-1:0]      r_iss_op;
    logic [NUM_FU*3-1:0]      r_iss_func3;
    logic [NUM_FU*7-1:0]      r_iss_func7;
    logic [NUM_FU*DATA_W-1:0] r_iss_src1;
    logic [NUM_FU*DATA_W-1:0] r_iss_src2;
    logic [NUM_FU*PREG_W-1:0] r_iss_pd;
    logic [NUM_FU*ROB_W-1:0]  r_iss_rob;

    // ---------------- combinational ----------------
    logic [DEPTH-1:0]    w_wk1_hit, w_wk2_hit;
    logic [DATA_W-1:0]   w_wk1_data [DEPTH];
    logic [DATA_W-1:0]   w_wk2_data [DEPTH];
    logic [DISP_W-1:0]   w_byp1_hit, w_byp2_hit;
    logic [DATA_W-1:0]   w_byp1_data [DISP_W];
    logic [DATA_W-1:0]   w_byp2_data [DISP_W];
    logic [DEPTH-1:0]    w_alloc;
    logic [c_SLOT_W-1:0] w_alloc_slot [DEPTH];
    logic                w_found;
    logic [6:0]          w_new_op    [DEPTH];
    logic [2:0]          w_new_func3 [DEPTH];
    logic [6:0]          w_new_func7 [DEPTH];
    logic [PREG_W-1:0]   w_new_pd    [DEPTH];
    logic [PREG_W-1:0]   w_new_ps1   [DEPTH];
    logic [PREG_W-1:0]   w_new_ps2   [DEPTH];
    logic [DATA_W-1:0]   w_new_data1 [DEPTH];
    logic [DATA_W-1:0]   w_new_data2 [DEPTH];
    logic [ROB_W-1:0]    w_new_rob   [DEPTH];
    logic [FU_W-1:0]     w_new_fu    [DEPTH];
    logic [DEPTH-1:0]    w_new_rdy1, w_new_rdy2;
    logic [DEPTH-1:0]    w_cand [NUM_FU];
    logic [NUM_FU-1:0]   w_any, w_load, w_take;
    logic [c_IDX_W-1:0]  w_sel [NUM_FU];
    logic [DEPTH-1:0]    w_free;
    logic [CNT_W-1:0]    w_n_alloc, w_n_take;

`ifdef RS_AGE_PRIO_EN
    // r_age[i][j] = 1 means entry i was dispatched before entry j.
    logic [DEPTH-1:0] r_age [DEPTH];
`endif

    assign disp_ready = (r_count <= CNT_W'(DEPTH - DISP_W));

    // Wakeup match for resident entries; the loop runs high to low so the
    // lowest-numbered matching port ends up winning.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            w_wk1_hit[i]  = 1'b0;
            w_wk2_hit[i]  = 1'b0;
            w_wk1_data[i] = '0;
            w_wk2_data[i] = '0;
            for (int j = WAKE_W - 1; j >= 0; j--) begin
                if (wk_valid[j] && wk_preg[j*PREG_W +: PREG_W] == r_ps1[i]) begin
                    w_wk1_hit[i]  = 1'b1;
                    w_wk1_data[i] = wk_data[j*DATA_W +: DATA_W];
                end
                if (wk_valid[j] && wk_preg[j*PREG_W +: PREG_W] == r_ps2[i]) begin
                    w_wk2_hit[i]  = 1'b1;
                    w_wk2_data[i] = wk_data[j*DATA_W +: DATA_W];
                end
            end
        end
    end

    // Same-cycle bypass for instructions being dispatched.
    always_comb begin
        for (int s = 0; s < DISP_W; s++) begin
            w_byp1_hit[s]  = 1'b0;
            w_byp2_hit[s]  = 1'b0;
            w_byp1_data[s] = '0;
            w_byp2_data[s] = '0;
            for (int j = WAKE_W - 1; j >= 0; j--) begin
                if (wk_valid[j] && wk_preg[j*PREG_W +: PREG_W] == disp_ps1[s*PREG_W +: PREG_W]) begin
                    w_byp1_hit[s]  = 1'b1;
                    w_byp1_data[s] = wk_data[j*DATA_W +: DATA_W];
                end
                if (wk_valid[j] && wk_preg[j*PREG_W +: PREG_W] == disp_ps2[s*PREG_W +: PREG_W]) begin
                    w_byp2_hit[s]  = 1'b1;
                    w_byp2_data[s] = wk_data[j*DATA_W +: DATA_W];
                end
            end
        end
    end

    // Allocation: valid slots, in slot order, take the lowest free entries.
    // Only start-of-cycle free entries are considered; entries issued this
    // cycle become available next cycle.
    always_comb begin
        w_alloc = '0;
        w_found = 1'b0;
        for (int i = 0; i < DEPTH; i++) w_alloc_slot[i] = '0;
        for (int s = 0; s < DISP_W; s++) begin
            w_found = 1'b0;
            if (disp_valid[s] && disp_ready && !flush) begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (!w_found && !r_valid[i] && !w_alloc[i]) begin
                        w_alloc[i]      = 1'b1;
                        w_alloc_slot[i] = c_SLOT_W'(s);
                        w_found         = 1'b1;
                    end
                end
            end
        end
    end

    // Per-entry view of the dispatch slot routed to it.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            w_new_op[i]    = '0;
            w_new_func3[i] = '0;
            w_new_func7[i] = '0;
            w_new_pd[i]    = '0;
            w_new_ps1[i]   = '0;
            w_new_ps2[i]   = '0;
            w_new_data1[i] = '0;
            w_new_data2[i] = '0;
            w_new_rob[i]   = '0;
            w_new_fu[i]    = '0;
            w_new_rdy1[i]  = 1'b0;
            w_new_rdy2[i]  = 1'b0;
            for (int s = 0; s < DISP_W; s++) begin
                if (w_alloc_slot[i] == c_SLOT_W'(s)) begin
                    w_new_op[i]    = disp_op[s*7 +: 7];
                    w_new_func3[i] = disp_func3[s*3 +: 3];
                    w_new_func7[i] = disp_func7[s*7 +: 7];
                    w_new_pd[i]    = disp_pd[s*PREG_W +: PREG_W];
                    w_new_ps1[i]   = disp_ps1[s*PREG_W +: PREG_W];
                    w_new_ps2[i]   = disp_ps2[s*PREG_W +: PREG_W];
                    w_new_rob[i]   = disp_rob_idx[s*ROB_W +: ROB_W];
                    w_new_fu[i]    = disp_fu_idx[s*FU_W +: FU_W];
                    w_new_rdy1[i]  = disp_src1_rdy[s] | w_byp1_hit[s];
                    w_new_rdy2[i]  = disp_src2_rdy[s] | w_byp2_hit[s];
                    w_new_data1[i] = (!disp_src1_rdy[s] && w_byp1_hit[s]) ?
                                     w_byp1_data[s] : disp_src1_data[s*DATA_W +: DATA_W];
                    w_new_data2[i] = (!disp_src2_rdy[s] && w_byp2_hit[s]) ?
                                     w_byp2_data[s] : disp_src2_data[s*DATA_W +: DATA_W];
                end
            end
        end
    end

    // Select from start-of-cycle state only, so a wakeup never issues in the
    // same cycle it arrives.
    always_comb begin
        for (int k = 0; k < NUM_FU; k++) begin
            w_any[k] = 1'b0;
            w_sel[k] = '0;
            for (int i = 0; i < DEPTH; i++)
                w_cand[k][i] = r_valid[i] & r_rdy1[i] & r_rdy2[i] & (r_fu[i] == FU_W'(k));
`ifdef RS_AGE_PRIO_EN
            // Oldest candidate: older than every other candidate.
            for (int i = 0; i < DEPTH; i++) begin
                if (w_cand[k][i] &&
                    ((w_cand[k] & ~r_age[i] & ~(DEPTH'(1) << i)) == '0)) begin
                    w_any[k] = 1'b1;
                    w_sel[k] = c_IDX_W'(i);
                end
            end
`else
            for (int i = DEPTH - 1; i >= 0; i--) begin
                if (w_cand[k][i]) begin
                    w_any[k] = 1'b1;
                    w_sel[k] = c_IDX_W'(i);
                end
            end
`endif
        end
    end

    assign w_load = ~r_iss_valid | iss_ready;
    assign w_take = w_load & w_any & {NUM_FU{~flush}};

    always_comb begin
        w_n_alloc = '0;
        w_n_take  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_free[i] = 1'b0;
            for (int k = 0; k < NUM_FU; k++)
                if (w_take[k] && w_sel[k] == c_IDX_W'(i)) w_free[i] = 1'b1;
            if (w_alloc[i]) w_n_alloc = w_n_alloc + CNT_W'(1);
        end
        for (int k = 0; k < NUM_FU; k++)
            if (w_take[k]) w_n_take = w_n_take + CNT_W'(1);
    end

    // Control state: valid/ready bits and occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= '0;
            r_rdy1  <= '0;
            r_rdy2  <= '0;
            r_count <= '0;
        end else if (flush) begin
            r_valid <= '0;
            r_count <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                r_valid[i] <= (r_valid[i] & ~w_free[i]) | w_alloc[i];
                if (w_alloc[i]) begin
                    r_rdy1[i] <= w_new_rdy1[i];
                    r_rdy2[i] <= w_new_rdy2[i];
                end else if (r_valid[i]) begin
                    if (w_wk1_hit[i]) r_rdy1[i] <= 1'b1;
                    if (w_wk2_hit[i]) r_rdy2[i] <= 1'b1;
                end
            end
            r_count <= r_count + w_n_alloc - w_n_take;
        end
    end

    // Payload storage; meaningful only while the matching valid bit is set.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (w_alloc[i]) begin
                r_op[i]    <= w_new_op[i];
                r_func3[i] <= w_new_func3[i];
                r_func7[i] <= w_new_func7[i];
                r_pd[i]    <= w_new_pd[i];
                r_ps1[i]   <= w_new_ps1[i];
                r_ps2[i]   <= w_new_ps2[i];
                r_data1[i] <= w_new_data1[i];
                r_data2[i] <= w_new_data2[i];
                r_rob[i]   <= w_new_rob[i];
                r_fu[i]    <= w_new_fu[i];
            end else begin
                if (r_valid[i] && !r_rdy1[i] && w_wk1_hit[i]) r_data1[i] <= w_wk1_data[i];
                if (r_valid[i] && !r_rdy2[i] && w_wk2_hit[i]) r_data2[i] <= w_wk2_data[i];
            end
        end
    end

`ifdef RS_AGE_PRIO_EN
    // A new entry is younger than everything already resident and than
    // lower-numbered slots dispatched alongside it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) r_age[i] <= '0;
        end else if (!flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                for (int j = 0; j < DEPTH; j++) begin
                    if (w_alloc[i])
                        r_age[i][j] <= w_alloc[j] && (w_alloc_slot[j] > w_alloc_slot[i]);
                    else if (w_alloc[j])
                        r_age[i][j] <= 1'b1;
                end
            end
        end
    end
`endif

    // Issue registers: reload when empty or being consumed, else hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_iss_valid <= '0;
            r_iss_op    <= '0;
            r_iss_func3 <= '0;
            r_iss_func7 <= '0;
            r_iss_src1  <= '0;
            r_iss_src2  <= '0;
            r_iss_pd    <= '0;
            r_iss_rob   <= '0;
        end else if (flush) begin
            r_iss_valid <= '0;
        end else begin
            for (int k = 0; k < NUM_FU; k++) begin
                if (w_load[k]) begin
                    r_iss_valid[k] <= w_any[k];
                    if (w_any[k]) begin
                        r_iss_op[k*7 +: 7]             <= r_op[w_sel[k]];
                        r_iss_func3[k*3 +: 3]          <= r_func3[w_sel[k]];
                        r_iss_func7[k*7 +: 7]          <= r_func7[w_sel[k]];
                        r_iss_src1[k*DATA_W +: DATA_W] <= r_data1[w_sel[k]];
                        r_iss_src2[k*DATA_W +: DATA_W] <= r_data2[w_sel[k]];
                        r_iss_pd[k*PREG_W +: PREG_W]   <= r_pd[w_sel[k]];
                        r_iss_rob[k*ROB_W +: ROB_W]    <= r_rob[w_sel[k]];
                    end
                end
            end
        end
    end

    assign iss_valid   = r_iss_valid;
    assign iss_op      = r_iss_op;
    assign iss_func3   = r_iss_func3;
    assign iss_func7   = r_iss_func7;
    assign iss_src1    = r_iss_src1;
    assign iss_src2    = r_iss_src2;
    assign iss_pd      = r_iss_pd;
    assign iss_rob_idx = r_iss_rob;
    assign occ_count   = r_count;

endmodule
`default_nettype wire

// File: tb/tb_rs_issue_queue.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rs_issue_queue
//  Description : Directed self-checking bench for rs_issue_queue with the
//                default parameter set (DEPTH 16, DISP_W 2, NUM_FU 3).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rs_issue_queue;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic [1:0]  disp_valid;
    logic        disp_ready;
    logic [13:0] disp_op, disp_func7;
    logic [5:0]  disp_func3;
    logic [11:0] disp_pd, disp_ps1, disp_ps2;
    logic [1:0]  disp_src1_rdy, disp_src2_rdy;
    logic [63:0] disp_src1_data, disp_src2_data;
    logic [7:0]  disp_rob_idx;
    logic [3:0]  disp_fu_idx;
    logic [2:0]  wk_valid;
    logic [17:0] wk_preg;
    logic [95:0] wk_data;
    logic [2:0]  iss_valid, iss_ready;
    logic [20:0] iss_op, iss_func7;
    logic [8:0]  iss_func3;
    logic [95:0] iss_src1, iss_src2;
    logic [17:0] iss_pd;
    logic [11:0] iss_rob_idx;
    logic [4:0]  occ_count;

    int errors = 0;
    int checks = 0;

`ifdef RS_AGE_PRIO_EN
    localparam bit c_AGE = 1'b1;
`else
    localparam bit c_AGE = 1'b0;
`endif

    always #5 clk = ~clk;

    rs_issue_queue dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .disp_valid(disp_valid), .disp_ready(disp_ready),
        .disp_op(disp_op), .disp_func3(disp_func3), .disp_func7(disp_func7),
        .disp_pd(disp_pd), .disp_ps1(disp_ps1), .disp_ps2(disp_ps2),
        .disp_src1_rdy(disp_src1_rdy), .disp_src2_rdy(disp_src2_rdy),
        .disp_src1_data(disp_src1_data), .disp_src2_data(disp_src2_data),
        .disp_rob_idx(disp_rob_idx), .disp_fu_idx(disp_fu_idx),
        .wk_valid(wk_valid), .wk_preg(wk_preg), .wk_data(wk_data),
        .iss_valid(iss_valid), .iss_ready(iss_ready),
        .iss_op(iss_op), .iss_func3(iss_func3), .iss_func7(iss_func7),
        .iss_src1(iss_src1), .iss_src2(iss_src2), .iss_pd(iss_pd),
        .iss_rob_idx(iss_rob_idx), .occ_count(occ_count)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs;
        flush = 1'b0;
        disp_valid = '0; disp_op = '0; disp_func3 = '0; disp_func7 = '0;
        disp_pd = '0; disp_ps1 = '0; disp_ps2 = '0;
        disp_src1_rdy = '0; disp_src2_rdy = '0;
        disp_src1_data = '0; disp_src2_data = '0;
        disp_rob_idx = '0; disp_fu_idx = '0;
        wk_valid = '0; wk_preg = '0; wk_data = '0;
    endtask

    task automatic set_slot(input int s, input logic [6:0] op, input logic [5:0] pd,
                            input logic [5:0] ps1, input logic [5:0] ps2,
                            input logic r1, input logic r2,
                            input logic [31:0] d1, input logic [31:0] d2,
                            input logic [3:0] rob, input logic [1:0] fu);
        disp_valid[s] = 1'b1;
        disp_op[s*7 +: 7] = op;
        disp_func3[s*3 +: 3] = 3'd0;
        disp_func7[s*7 +: 7] = 7'd0;
        disp_pd[s*6 +: 6] = pd;
        disp_ps1[s*6 +: 6] = ps1;
        disp_ps2[s*6 +: 6] = ps2;
        disp_src1_rdy[s] = r1;
        disp_src2_rdy[s] = r2;
        disp_src1_data[s*32 +: 32] = d1;
        disp_src2_data[s*32 +: 32] = d2;
        disp_rob_idx[s*4 +: 4] = rob;
        disp_fu_idx[s*2 +: 2] = fu;
    endtask

    task automatic set_wake(input int j, input logic [5:0] tag, input logic [31:0] d);
        wk_valid[j] = 1'b1;
        wk_preg[j*6 +: 6] = tag;
        wk_data[j*32 +: 32] = d;
    endtask

    task automatic test_reset;
        clear_inputs();
        iss_ready = 3'b111;
        rst_n = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        tick();
        checks++; if (iss_valid !== 3'b000) begin errors++; $display("FAIL reset_iss_valid: got %b expected 000", iss_valid); end
        checks++; if (occ_count !== 5'd0) begin errors++; $display("FAIL reset_occ: got %0d expected 0", occ_count); end
        checks++; if (disp_ready !== 1'b1) begin errors++; $display("FAIL reset_disp_ready: got %b expected 1", disp_ready); end
        checks++; if (iss_src1 !== 96'd0 || iss_op !== 21'd0) begin errors++; $display("FAIL reset_iss_data: src1 %h op %h expected 0", iss_src1, iss_op); end
    endtask

    task automatic test_addi;
        set_slot(0, 7'h13, 6'd10, 6'd5, 6'd0, 1'b1, 1'b1, 32'd7, 32'd3, 4'd1, 2'd0);
        tick();
        clear_inputs();
        checks++; if (occ_count !== 5'd1) begin errors++; $display("FAIL addi_occ_t1: got %0d expected 1", occ_count); end
        checks++; if (iss_valid !== 3'b000) begin errors++; $display("FAIL addi_no_early_issue: got %b expected 000", iss_valid); end
        tick();
        checks++; if (iss_valid !== 3'b001) begin errors++; $display("FAIL addi_iss_valid: got %b expected 001", iss_valid); end
        checks++; if (iss_src1[31:0] !== 32'd7 || iss_src2[31:0] !== 32'd3) begin errors++; $display("FAIL addi_src: got %0d/%0d expected 7/3", iss_src1[31:0], iss_src2[31:0]); end
        checks++; if (iss_op[6:0] !== 7'h13 || iss_pd[5:0] !== 6'd10 || iss_rob_idx[3:0] !== 4'd1) begin errors++; $display("FAIL addi_fields: op %h pd %0d rob %0d expected 13/10/1", iss_op[6:0], iss_pd[5:0], iss_rob_idx[3:0]); end
        checks++; if (occ_count !== 5'd0) begin errors++; $display("FAIL addi_occ_t2: got %0d expected 0", occ_count); end
        tick();
        checks++; if (iss_valid !== 3'b000) begin errors++; $display("FAIL addi_clear: got %b expected 000", iss_valid); end
    endtask

    task automatic test_back_to_back;
        set_slot(0, 7'h33, 6'd11, 6'd1, 6'd2, 1'b1, 1'b1, 32'h55, 32'h1, 4'd2, 2'd0);
        set_slot(1, 7'h03, 6'd12, 6'd3, 6'd4, 1'b1, 1'b1, 32'h66, 32'h2, 4'd3, 2'd1);
        tick();
        clear_inputs();
        checks++; if (occ_count !== 5'd2) begin errors++; $display("FAIL dual_occ: got %0d expected 2", occ_count); end
        tick();
        checks++; if (iss_valid !== 3'b011) begin errors++; $display("FAIL dual_iss_valid: got %b expected 011", iss_valid); end
        checks++; if (iss_src1[31:0] !== 32'h55 || iss_src1[63:32] !== 32'h66) begin errors++; $display("FAIL dual_src1: got %h/%h expected 55/66", iss_src1[31:0], iss_src1[63:32]); end
        checks++; if (iss_rob_idx[3:0] !== 4'd2 || iss_rob_idx[7:4] !== 4'd3) begin errors++; $display("FAIL dual_rob: got %0d/%0d expected 2/3", iss_rob_idx[3:0], iss_rob_idx[7:4]); end
        tick();
    endtask

    task automatic test_wakeup;
        set_slot(0, 7'h33, 6'd13, 6'd3, 6'd9, 1'b1, 1'b0, 32'd5, 32'd0, 4'd4, 2'd1);
        tick();
        clear_inputs();
        tick(); tick();
        checks++; if (iss_valid[1] !== 1'b0) begin errors++; $display("FAIL wake_premature: got %b expected 0", iss_valid[1]); end
        set_wake(1, 6'd9, 32'h10);
        tick();
        clear_inputs();
        checks++; if (iss_valid[1] !== 1'b0) begin errors++; $display("FAIL wake_same_cycle_issue: got %b expected 0", iss_valid[1]); end
        tick();
        checks++; if (iss_valid[1] !== 1'b1) begin errors++; $display("FAIL wake_iss_valid: got %b expected 1", iss_valid[1]); end
        checks++; if (iss_src2[63:32] !== 32'h10 || iss_src1[63:32] !== 32'd5) begin errors++; $display("FAIL wake_src: got %h/%h expected 5/10", iss_src1[63:32], iss_src2[63:32]); end
        tick();
    endtask

    task automatic test_bypass;
        set_slot(0, 7'h33, 6'd14, 6'd4, 6'd9, 1'b1, 1'b0, 32'd1, 32'd0, 4'd5, 2'd0);
        set_wake(0, 6'd9, 32'h22);
        set_wake(2, 6'd9, 32'h33);
        tick();
        clear_inputs();
        checks++; if (iss_valid[0] !== 1'b0) begin errors++; $display("FAIL byp_early: got %b expected 0", iss_valid[0]); end
        tick();
        checks++; if (iss_valid[0] !== 1'b1) begin errors++; $display("FAIL byp_iss_valid: got %b expected 1", iss_valid[0]); end
        checks++; if (iss_src2[31:0] !== 32'h22) begin errors++; $display("FAIL byp_lowest_port: got %h expected 22", iss_src2[31:0]); end
        tick();
    endtask

    task automatic test_full;
        int n;
        int cnt;
        logic [15:0] mask;
        logic [3:0] idx;
        n = 0;
        iss_ready = 3'b000;
        for (int c = 0; c < 20 && disp_ready; c++) begin
            set_slot(0, 7'h13, 6'(n + 1), 6'd0, 6'd0, 1'b1, 1'b1, 32'(n), 32'd0, 4'(n), 2'd2);
            set_slot(1, 7'h13, 6'(n + 2), 6'd0, 6'd0, 1'b1, 1'b1, 32'(n + 1), 32'd0, 4'(n + 1), 2'd2);
            n += 2;
            tick();
            clear_inputs();
        end
        checks++; if (n !== 16) begin errors++; $display("FAIL full_accepted: got %0d expected 16", n); end
        checks++; if (occ_count !== 5'd15) begin errors++; $display("FAIL full_occ: got %0d expected 15", occ_count); end
        checks++; if (disp_ready !== 1'b0) begin errors++; $display("FAIL full_disp_ready: got %b expected 0", disp_ready); end
        checks++; if (iss_valid !== 3'b100 || iss_src1[95:64] !== 32'd0) begin errors++; $display("FAIL full_head: valid %b src1 %0d expected 100/0", iss_valid, iss_src1[95:64]); end
        set_slot(0, 7'h13, 6'd40, 6'd0, 6'd0, 1'b1, 1'b1, 32'd99, 32'd0, 4'd0, 2'd2);
        tick();
        clear_inputs();
        tick();
        checks++; if (occ_count !== 5'd15) begin errors++; $display("FAIL full_drop: got %0d expected 15", occ_count); end
        checks++; if (iss_valid[2] !== 1'b1 || iss_src1[95:64] !== 32'd0 || iss_pd[17:12] !== 6'd1) begin errors++; $display("FAIL full_hold: valid %b src1 %0d pd %0d expected 1/0/1", iss_valid[2], iss_src1[95:64], iss_pd[17:12]); end
        iss_ready = 3'b100;
        mask = '0;
        cnt = 0;
        for (int c = 0; c < 40; c++) begin
            if (!iss_valid[2]) break;
            if (cnt == 5) begin
                checks++; if (occ_count !== 5'd10) begin errors++; $display("FAIL drain_rate: got %0d expected 10", occ_count); end
            end
            idx = iss_src1[67:64];
            mask[idx] = 1'b1;
            cnt++;
            tick();
        end
        checks++; if (cnt !== 16) begin errors++; $display("FAIL drain_count: got %0d expected 16", cnt); end
        checks++; if (mask !== 16'hFFFF) begin errors++; $display("FAIL drain_set: got %h expected ffff", mask); end
        checks++; if (occ_count !== 5'd0 || disp_ready !== 1'b1) begin errors++; $display("FAIL drain_empty: occ %0d ready %b expected 0/1", occ_count, disp_ready); end
        iss_ready = 3'b111;
    endtask

    task automatic test_age;
        logic [31:0] exp1;
        logic [31:0] exp2;
        iss_ready = 3'b111;
        set_slot(0, 7'h33, 6'd30, 6'd20, 6'd0, 1'b0, 1'b1, 32'd0, 32'hA0, 4'd0, 2'd0);
        set_slot(1, 7'h33, 6'd31, 6'd21, 6'd0, 1'b0, 1'b1, 32'd0, 32'hA1, 4'd1, 2'd0);
        tick(); clear_inputs();
        set_slot(0, 7'h33, 6'd32, 6'd22, 6'd0, 1'b0, 1'b1, 32'd0, 32'hA2, 4'd2, 2'd0);
        set_slot(1, 7'h33, 6'd33, 6'd23, 6'd0, 1'b0, 1'b1, 32'd0, 32'hA3, 4'd3, 2'd0);
        tick(); clear_inputs();
        set_slot(0, 7'h33, 6'd34, 6'd24, 6'd0, 1'b0, 1'b1, 32'd0, 32'hA4, 4'd4, 2'd0);
        set_wake(0, 6'd21, 32'h11);
        tick(); clear_inputs();
        tick();
        checks++; if (iss_valid[0] !== 1'b1 || iss_src2[31:0] !== 32'hA1 || iss_src1[31:0] !== 32'h11) begin errors++; $display("FAIL age_free1: valid %b src %h/%h expected 1/11/a1", iss_valid[0], iss_src1[31:0], iss_src2[31:0]); end
        set_slot(0, 7'h33, 6'd35, 6'd25, 6'd0, 1'b0, 1'b1, 32'd0, 32'hA5, 4'd5, 2'd0);
        tick(); clear_inputs();
        checks++; if (occ_count !== 5'd5) begin errors++; $display("FAIL age_occ: got %0d expected 5", occ_count); end
        set_wake(0, 6'd24, 32'h44);
        set_wake(1, 6'd25, 32'h55);
        tick(); clear_inputs();
        tick();
        exp1 = c_AGE ? 32'hA4 : 32'hA5;
        exp2 = c_AGE ? 32'hA5 : 32'hA4;
        checks++; if (iss_valid[0] !== 1'b1 || iss_src2[31:0] !== exp1) begin errors++; $display("FAIL age_first: valid %b src2 %h expected 1/%h", iss_valid[0], iss_src2[31:0], exp1); end
        tick();
        checks++; if (iss_valid[0] !== 1'b1 || iss_src2[31:0] !== exp2) begin errors++; $display("FAIL age_second: valid %b src2 %h expected 1/%h", iss_valid[0], iss_src2[31:0], exp2); end
        tick();
        checks++; if (iss_valid[0] !== 1'b0) begin errors++; $display("FAIL age_done: got %b expected 0", iss_valid[0]); end
    endtask

    task automatic test_flush;
        flush = 1'b1;
        tick(); clear_inputs();
        iss_ready = 3'b000;
        set_slot(0, 7'h13, 6'd1, 6'd0, 6'd0, 1'b1, 1'b1, 32'h100, 32'd0, 4'd0, 2'd0);
        set_slot(1, 7'h13, 6'd2, 6'd0, 6'd0, 1'b1, 1'b1, 32'h101, 32'd0, 4'd1, 2'd0);
        tick(); clear_inputs();
        set_slot(0, 7'h13, 6'd3, 6'd0, 6'd0, 1'b1, 1'b1, 32'h102, 32'd0, 4'd2, 2'd0);
        set_slot(1, 7'h13, 6'd4, 6'd0, 6'd0, 1'b1, 1'b1, 32'h103, 32'd0, 4'd3, 2'd0);
        tick(); clear_inputs();
        set_slot(0, 7'h33, 6'd5, 6'd30, 6'd0, 1'b0, 1'b1, 32'd0, 32'd0, 4'd4, 2'd0);
        set_slot(1, 7'h33, 6'd6, 6'd31, 6'd0, 1'b0, 1'b1, 32'd0, 32'd0, 4'd5, 2'd0);
        tick(); clear_inputs();
        checks++; if (occ_count !== 5'd5 || iss_valid[0] !== 1'b1) begin errors++; $display("FAIL flush_setup: occ %0d valid %b expected 5/1", occ_count, iss_valid[0]); end
        flush = 1'b1;
        set_slot(0, 7'h13, 6'd7, 6'd0, 6'd0, 1'b1, 1'b1, 32'h1, 32'd0, 4'd6, 2'd0);
        set_wake(0, 6'd30, 32'h7);
        tick(); clear_inputs();
        checks++; if (occ_count !== 5'd0 || iss_valid !== 3'b000 || disp_ready !== 1'b1) begin errors++; $display("FAIL flush_clear: occ %0d valid %b ready %b expected 0/000/1", occ_count, iss_valid, disp_ready); end
        iss_ready = 3'b111;
        tick(); tick();
        checks++; if (occ_count !== 5'd0 || iss_valid !== 3'b000) begin errors++; $display("FAIL flush_ignored: occ %0d valid %b expected 0/000", occ_count, iss_valid); end
    endtask

    task automatic test_async_reset;
        set_slot(0, 7'h33, 6'd1, 6'd40, 6'd0, 1'b0, 1'b1, 32'd0, 32'd0, 4'd0, 2'd0);
        set_slot(1, 7'h33, 6'd2, 6'd41, 6'd0, 1'b0, 1'b1, 32'd0, 32'd0, 4'd1, 2'd1);
        tick(); clear_inputs();
        checks++; if (occ_count !== 5'd2) begin errors++; $display("FAIL areset_setup: got %0d expected 2", occ_count); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (occ_count !== 5'd0 || disp_ready !== 1'b1) begin errors++; $display("FAIL areset_immediate: occ %0d ready %b expected 0/1", occ_count, disp_ready); end
        #2 rst_n = 1'b1;
        tick();
    endtask

    initial begin
        test_reset();
        test_addi();
        test_back_to_back();
        test_wakeup();
        test_bypass();
        test_full();
        test_age();
        test_flush();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
`default_nettype wire
